// File: rtl/ctrl_pipe_hazard.sv
// ctrl_pipe_hazard
// This block is the downstream end of the ID-stage control decode. It carries the
// decoded controls and register specifiers through the ID/EX, EX/MEM and MEM/WB
// pipeline registers. It also detects load-use hazards and resolves taken branches
// in MEM.
//
// Ports
//   clk_i, reset_i           clock and synchronous active-high reset
//   id_*_i                   decoded controls and rs/rt/rd specifiers from ID
//   ex_zero_i                ALU zero flag of the instruction currently in EX
//   hazard_o                 load-use stall: PC write-disable, IF/ID hold, decoder hazard
//   pc_src_o                 taken branch in MEM: PC mux select, IF/ID flush
//   ex_*_o                   EX-stage controls and rs/rt for forwarding
//   mem_*_o                  MEM-stage controls, destination register and write enable
//   wb_*_o                   WB-stage controls and destination register
//   stall_cnt_o/flush_cnt_o  saturating counts of stall and flush cycles
module ctrl_pipe_hazard #(
  parameter int RAW   = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             id_RegDst_i,
  input  logic             id_branch_i,
  input  logic             id_MemRead_i,
  input  logic             id_MemtoReg_i,
  input  logic             id_MemWrite_i,
  input  logic             id_AluSrc_i,
  input  logic             id_RegWrite_i,
  input  logic [1:0]       id_ALUop_i,
  input  logic [RAW-1:0]   id_rs_i,
  input  logic [RAW-1:0]   id_rt_i,
  input  logic [RAW-1:0]   id_rd_i,
  input  logic             ex_zero_i,
  output logic             hazard_o,
  output logic             pc_src_o,
  output logic             ex_RegDst_o,
  output logic             ex_AluSrc_o,
  output logic             ex_MemRead_o,
  output logic [1:0]       ex_ALUop_o,
  output logic [RAW-1:0]   ex_rs_o,
  output logic [RAW-1:0]   ex_rt_o,
  output logic             mem_MemRead_o,
  output logic             mem_MemWrite_o,
  output logic [RAW-1:0]   mem_wreg_o,
  output logic             mem_RegWrite_o,
  output logic             wb_MemtoReg_o,
  output logic             wb_RegWrite_o,
  output logic [RAW-1:0]   wb_wreg_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef struct packed {
    logic           reg_dst;
    logic           alu_src;
    logic           mem_read;
    logic [1:0]     alu_op;
    logic           branch;
    logic           mem_write;
    logic           mem_to_reg;
    logic           reg_write;
    logic [RAW-1:0] rs;
    logic [RAW-1:0] rt;
    logic [RAW-1:0] rd;
  } idex_t;

  typedef struct packed {
    logic           branch;
    logic           zero;
    logic           mem_read;
    logic           mem_write;
    logic           mem_to_reg;
    logic           reg_write;
    logic [RAW-1:0] wreg;
  } exmem_t;

  typedef struct packed {
    logic           mem_to_reg;
    logic           reg_write;
    logic [RAW-1:0] wreg;
  } memwb_t;

  localparam idex_t          IDEX_BUBBLE  = '0;
  localparam exmem_t         EXMEM_BUBBLE = '0;
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [RAW-1:0]   REG_ZERO   = {RAW{1'b0}};

  idex_t            ex_d, ex_q;
  exmem_t           mem_d, mem_q;
  memwb_t           wb_d, wb_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
  logic             pc_src;
  logic             hazard;

  // Branch resolution in MEM and load-use detection; a taken branch masks the
  // stall because the instruction that would be stalled is squashed anyway.
  always_comb begin
    pc_src = mem_q.branch & mem_q.zero;
    hazard = ex_q.mem_read & (ex_q.rt != REG_ZERO)
           & ((ex_q.rt == id_rs_i) | (ex_q.rt == id_rt_i)) & ~pc_src;
  end

  // Next-state of the three pipeline registers and the event counters.
  always_comb begin
    ex_d        = IDEX_BUBBLE;
    mem_d       = EXMEM_BUBBLE;
    wb_d        = '{mem_to_reg: mem_q.mem_to_reg, reg_write: mem_q.reg_write, wreg: mem_q.wreg};
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (hazard | pc_src) begin
      ex_d = IDEX_BUBBLE;
    end else begin
      ex_d = '{reg_dst:   id_RegDst_i,   alu_src:    id_AluSrc_i,
               mem_read:  id_MemRead_i,  alu_op:     id_ALUop_i,
               branch:    id_branch_i,   mem_write:  id_MemWrite_i,
               mem_to_reg: id_MemtoReg_i, reg_write: id_RegWrite_i,
               rs: id_rs_i, rt: id_rt_i, rd: id_rd_i};
    end

    if (pc_src) begin
      mem_d = EXMEM_BUBBLE;
    end else begin
      mem_d = '{branch:     ex_q.branch,     zero:      ex_zero_i,
                mem_read:   ex_q.mem_read,   mem_write: ex_q.mem_write,
                mem_to_reg: ex_q.mem_to_reg, reg_write: ex_q.reg_write,
                wreg:       ex_q.reg_dst ? ex_q.rd : ex_q.rt};
    end

    if (hazard && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end

    if (pc_src && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State registers; reset clears everything and overrides stall and flush.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ex_q        <= IDEX_BUBBLE;
      mem_q       <= EXMEM_BUBBLE;
      wb_q        <= '0;
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hazard_o       = hazard;
  assign pc_src_o       = pc_src;
  assign ex_RegDst_o    = ex_q.reg_dst;
  assign ex_AluSrc_o    = ex_q.alu_src;
  assign ex_MemRead_o   = ex_q.mem_read;
  assign ex_ALUop_o     = ex_q.alu_op;
  assign ex_rs_o        = ex_q.rs;
  assign ex_rt_o        = ex_q.rt;
  assign mem_MemRead_o  = mem_q.mem_read;
  assign mem_MemWrite_o = mem_q.mem_write;
  assign mem_wreg_o     = mem_q.wreg;
  assign mem_RegWrite_o = mem_q.reg_write;
  assign wb_MemtoReg_o  = wb_q.mem_to_reg;
  assign wb_RegWrite_o  = wb_q.reg_write;
  assign wb_wreg_o      = wb_q.wreg;
  assign stall_cnt_o    = stall_cnt_q;
  assign flush_cnt_o    = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Testbench for ctrl_pipe_hazard. It runs directed scenarios and then random
// instruction streams. All of them are checked against an instruction-slot model
// of the pipeline.
module tb_ctrl_pipe_hazard;
  localparam int RAW   = 5;
  localparam int CNT_W = 2;
  localparam int CMAX  = 3;

  typedef struct packed {
    logic           regdst;
    logic           branch;
    logic           memread;
    logic           memtoreg;
    logic           memwrite;
    logic           alusrc;
    logic           regwrite;
    logic [1:0]     aluop;
    logic [RAW-1:0] rs;
    logic [RAW-1:0] rt;
    logic [RAW-1:0] rd;
  } instr_t;

  // One pipeline slot: valid flag, zero flag seen while in EX, the instruction.
  typedef struct packed {
    logic   v;
    logic   z;
    instr_t i;
  } slot_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   zero_in = 1'b0;
  instr_t cur = '0;

  logic             hazard, pc_src, ex_RegDst, ex_AluSrc, ex_MemRead;
  logic [1:0]       ex_ALUop;
  logic [RAW-1:0]   ex_rs, ex_rt, mem_wreg, wb_wreg;
  logic             mem_MemRead, mem_MemWrite, mem_RegWrite, wb_MemtoReg, wb_RegWrite;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  slot_t m_ex = '0, m_mem = '0, m_wb = '0;
  int    m_stall = 0, m_flush = 0;
  int    n_checks = 0, n_fail = 0;
  logic  chk_en = 1'b0;

  always #5 clk = ~clk;

  ctrl_pipe_hazard #(.RAW(RAW), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .reset_i(rst),
    .id_RegDst_i(cur.regdst), .id_branch_i(cur.branch), .id_MemRead_i(cur.memread),
    .id_MemtoReg_i(cur.memtoreg), .id_MemWrite_i(cur.memwrite), .id_AluSrc_i(cur.alusrc),
    .id_RegWrite_i(cur.regwrite), .id_ALUop_i(cur.aluop),
    .id_rs_i(cur.rs), .id_rt_i(cur.rt), .id_rd_i(cur.rd),
    .ex_zero_i(zero_in),
    .hazard_o(hazard), .pc_src_o(pc_src),
    .ex_RegDst_o(ex_RegDst), .ex_AluSrc_o(ex_AluSrc), .ex_MemRead_o(ex_MemRead),
    .ex_ALUop_o(ex_ALUop), .ex_rs_o(ex_rs), .ex_rt_o(ex_rt),
    .mem_MemRead_o(mem_MemRead), .mem_MemWrite_o(mem_MemWrite),
    .mem_wreg_o(mem_wreg), .mem_RegWrite_o(mem_RegWrite),
    .wb_MemtoReg_o(wb_MemtoReg), .wb_RegWrite_o(wb_RegWrite), .wb_wreg_o(wb_wreg),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  function automatic logic m_pc();
    return m_mem.v & m_mem.i.branch & m_mem.z;
  endfunction

  function automatic logic m_hz();
    return m_ex.v & m_ex.i.memread & (m_ex.i.rt != 5'd0)
         & ((m_ex.i.rt == cur.rs) | (m_ex.i.rt == cur.rt)) & ~m_pc();
  endfunction

  function automatic logic [RAW-1:0] dest(input slot_t s);
    if (!s.v) return 5'd0;
    return s.i.regdst ? s.i.rd : s.i.rt;
  endfunction

  // Advance the model by one clock edge using the inputs held during the cycle.
  task automatic model_step();
    logic pc, hz;
    if (rst) begin
      m_ex = '0; m_mem = '0; m_wb = '0; m_stall = 0; m_flush = 0;
    end else begin
      pc = m_pc();
      hz = m_hz();
      if (hz && m_stall < CMAX) m_stall++;
      if (pc && m_flush < CMAX) m_flush++;
      m_wb = m_mem;
      if (pc) m_mem = '0;
      else begin m_mem = m_ex; m_mem.z = zero_in; end
      if (hz || pc) m_ex = '0;
      else begin m_ex.v = 1'b1; m_ex.z = 1'b0; m_ex.i = cur; end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("hazard",       hazard,       m_hz());
      chk("pc_src",       pc_src,       m_pc());
      chk("ex_RegDst",    ex_RegDst,    m_ex.v & m_ex.i.regdst);
      chk("ex_AluSrc",    ex_AluSrc,    m_ex.v & m_ex.i.alusrc);
      chk("ex_MemRead",   ex_MemRead,   m_ex.v & m_ex.i.memread);
      chk("ex_ALUop",     ex_ALUop,     {2{m_ex.v}} & m_ex.i.aluop);
      chk("ex_rs",        ex_rs,        {RAW{m_ex.v}} & m_ex.i.rs);
      chk("ex_rt",        ex_rt,        {RAW{m_ex.v}} & m_ex.i.rt);
      chk("mem_MemRead",  mem_MemRead,  m_mem.v & m_mem.i.memread);
      chk("mem_MemWrite", mem_MemWrite, m_mem.v & m_mem.i.memwrite);
      chk("mem_RegWrite", mem_RegWrite, m_mem.v & m_mem.i.regwrite);
      chk("mem_wreg",     mem_wreg,     dest(m_mem));
      chk("wb_MemtoReg",  wb_MemtoReg,  m_wb.v & m_wb.i.memtoreg);
      chk("wb_RegWrite",  wb_RegWrite,  m_wb.v & m_wb.i.regwrite);
      chk("wb_wreg",      wb_wreg,      dest(m_wb));
      chk("stall_cnt",    stall_cnt,    m_stall);
      chk("flush_cnt",    flush_cnt,    m_flush);
    end
  end

  task automatic step(input instr_t ins, input logic z);
    cur = ins;
    zero_in = z;
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic instr_t mk_r(input int rs, input int rt, input int rd);
    instr_t r = '0;
    r.regdst = 1'b1; r.aluop = 2'b10; r.regwrite = 1'b1;
    r.rs = rs[RAW-1:0]; r.rt = rt[RAW-1:0]; r.rd = rd[RAW-1:0];
    return r;
  endfunction

  function automatic instr_t mk_lw(input int rs, input int rt);
    instr_t r = '0;
    r.memread = 1'b1; r.memtoreg = 1'b1; r.alusrc = 1'b1; r.regwrite = 1'b1;
    r.rs = rs[RAW-1:0]; r.rt = rt[RAW-1:0];
    return r;
  endfunction

  function automatic instr_t mk_beq(input int rs, input int rt);
    instr_t r = '0;
    r.branch = 1'b1; r.aluop = 2'b01;
    r.rs = rs[RAW-1:0]; r.rt = rt[RAW-1:0];
    return r;
  endfunction

  function automatic instr_t rnd_instr();
    instr_t r;
    r.regdst   = 1'($urandom_range(0, 1));
    r.branch   = ($urandom_range(0, 3) == 0);
    r.memread  = ($urandom_range(0, 2) == 0);
    r.memtoreg = 1'($urandom_range(0, 1));
    r.memwrite = 1'($urandom_range(0, 1));
    r.alusrc   = 1'($urandom_range(0, 1));
    r.regwrite = 1'($urandom_range(0, 1));
    r.aluop    = 2'($urandom_range(0, 3));
    r.rs       = 5'($urandom_range(0, 3));
    r.rt       = 5'($urandom_range(0, 3));
    r.rd       = 5'($urandom_range(0, 31));
    return r;
  endfunction

  initial begin
    instr_t nop;
    nop = '0;

    // Reset held two cycles with random ID inputs.
    rst = 1'b1;
    step(rnd_instr(), 1'($urandom_range(0, 1)));
    step(rnd_instr(), 1'($urandom_range(0, 1)));
    chk_en = 1'b1;
    chk("rst_hazard", hazard, 0);
    chk("rst_pc_src", pc_src, 0);
    chk("rst_ex_ALUop", ex_ALUop, 0);
    chk("rst_mem_wreg", mem_wreg, 0);
    chk("rst_wb_RegWrite", wb_RegWrite, 0);
    chk("rst_stall_cnt", stall_cnt, 0);

    // R-type latency through the pipe.
    rst = 1'b0;
    step(mk_r(1, 2, 5), 1'b0);
    chk("lat_ex_ALUop", ex_ALUop, 2);
    chk("lat_ex_RegDst", ex_RegDst, 1);
    step(nop, 1'b0);
    chk("lat_mem_wreg", mem_wreg, 5);
    step(nop, 1'b0);
    chk("lat_wb_RegWrite", wb_RegWrite, 1);
    chk("lat_wb_wreg", wb_wreg, 5);

    // Load-use stall.
    step(mk_lw(1, 3), 1'b0);
    cur = mk_r(3, 7, 8);
    #1;
    chk("lu_hazard", hazard, 1);
    step(mk_r(3, 7, 8), 1'b0);
    chk("lu_bubble_MemRead", ex_MemRead, 0);
    chk("lu_bubble_ALUop", ex_ALUop, 0);
    chk("lu_bubble_rs", ex_rs, 0);
    chk("lu_hazard_once", hazard, 0);
    chk("lu_stall_cnt", stall_cnt, 1);
    step(mk_r(3, 7, 8), 1'b0);
    chk("lu_replay_rs", ex_rs, 3);
    chk("lu_replay_ALUop", ex_ALUop, 2);

    // Register 0 and no dependency.
    step(mk_lw(1, 0), 1'b0);
    cur = mk_r(0, 0, 9);
    #1;
    chk("r0_hazard", hazard, 0);
    step(mk_r(0, 0, 9), 1'b0);
    step(mk_lw(2, 4), 1'b0);
    cur = mk_r(6, 7, 9);
    #1;
    chk("nodep_hazard", hazard, 0);
    step(mk_r(6, 7, 9), 1'b0);
    chk("nodep_stall_cnt", stall_cnt, 1);

    // Taken branch.
    step(mk_beq(1, 2), 1'b0);
    step(mk_r(1, 1, 10), 1'b1);
    chk("br_pc_src", pc_src, 1);
    step(mk_r(2, 2, 11), 1'b0);
    chk("br_sq_ex_rs", ex_rs, 0);
    chk("br_sq_ex_ALUop", ex_ALUop, 0);
    chk("br_sq_mem_RegWrite", mem_RegWrite, 0);
    chk("br_sq_mem_wreg", mem_wreg, 0);
    chk("br_flush_cnt", flush_cnt, 1);

    // Untaken branch.
    step(mk_beq(1, 2), 1'b0);
    step(mk_r(1, 1, 10), 1'b0);
    chk("nt_pc_src", pc_src, 0);
    step(mk_r(2, 2, 11), 1'b0);
    chk("nt_ex_rs", ex_rs, 2);
    chk("nt_mem_RegWrite", mem_RegWrite, 1);
    chk("nt_mem_wreg", mem_wreg, 10);
    chk("nt_flush_cnt", flush_cnt, 1);

    // Simultaneous hazard and flush: the flush wins.
    step(mk_beq(1, 2), 1'b0);
    step(mk_lw(1, 3), 1'b1);
    cur = mk_r(3, 7, 8);
    #1;
    chk("sim_pc_src", pc_src, 1);
    chk("sim_hazard", hazard, 0);
    step(mk_r(3, 7, 8), 1'b0);
    chk("sim_ex_MemRead", ex_MemRead, 0);
    chk("sim_ex_rs", ex_rs, 0);
    chk("sim_mem_MemRead", mem_MemRead, 0);
    chk("sim_stall_cnt", stall_cnt, 1);
    chk("sim_flush_cnt", flush_cnt, 2);

    // Counter saturation at CNT_W=2.
    for (int k = 0; k < 4; k++) begin
      step(mk_lw(1, 3), 1'b0);
      step(mk_r(3, 7, 8), 1'b0);
      step(mk_r(3, 7, 8), 1'b0);
    end
    chk("sat_stall_cnt", stall_cnt, 3);
    for (int k = 0; k < 2; k++) begin
      step(mk_beq(1, 2), 1'b0);
      step(nop, 1'b1);
      step(nop, 1'b0);
    end
    chk("sat_flush_cnt", flush_cnt, 3);

    // Reset with LW, BEQ and R-type in flight.
    step(mk_lw(1, 9), 1'b0);
    step(mk_beq(1, 2), 1'b0);
    step(mk_r(4, 5, 6), 1'b0);
    rst = 1'b1;
    step(rnd_instr(), 1'b1);
    chk("mid_ex_RegDst", ex_RegDst, 0);
    chk("mid_mem_RegWrite", mem_RegWrite, 0);
    chk("mid_wb_RegWrite", wb_RegWrite, 0);
    chk("mid_pc_src", pc_src, 0);
    chk("mid_stall_cnt", stall_cnt, 0);
    chk("mid_flush_cnt", flush_cnt, 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(nop, 1'b0);
      chk("mid_no_wb_pulse", wb_RegWrite, 0);
    end

    // Random instruction streams with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 63) == 0);
      step(rnd_instr(), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
